// File: rtl/activation_pipe.sv
// activation_pipe: 3-stage fixed-point activation pipeline (bypass/ReLU/ReLU6/HSigmoid/HSwish).
// All stages advance together on a single enable derived from output backpressure.
module activation_pipe #(
   parameter int N        = 16,
   parameter int FRAC     = 8,
   parameter int CHANNELS = 16,
   localparam int CW      = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] in_data,
   input  logic [CW-1:0]       in_channel,
   input  logic [2:0]          in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] out_data,
   output logic [CW-1:0]       out_channel,
   output logic                busy
);
   localparam int P = 2*N+4;
   localparam logic signed [N:0]   C3  = (N+1)'(3) << FRAC;
   localparam logic signed [N:0]   C6X = (N+1)'(6) << FRAC;
   localparam logic signed [N-1:0] C6  = N'(6) << FRAC;
   localparam logic signed [P-1:0] C6W = P'(6) << FRAC;
   localparam logic signed [N-1:0] SIX = N'(6);
   logic adv, v1_q, v2_q, ov_q;
   logic signed [N-1:0] x1_q, x2_q, r2_q, relu2_q, relu62_q, od_q;
   logic signed [N-1:0] r_d, relu_d, relu6_d, y_d;
   logic signed [N:0]   xp1_q, xp_d;
   logic signed [P-1:0] prod, hsw;
   logic [CW-1:0] ch1_q, ch2_q, oc_q;
   logic [2:0]    m1_q, m2_q;

   // In range iff all bits above the sign position agree with it
   function automatic logic signed [N-1:0] sat(input logic signed [P-1:0] v);
      return (&v[P-1:N-1] || ~|v[P-1:N-1]) ? v[N-1:0] : {v[P-1], {(N-1){~v[P-1]}}};
   endfunction

   always_comb begin
      xp_d    = {in_data[N-1], in_data} + C3;
      r_d     = xp1_q[N] ? '0 : (xp1_q > C6X) ? C6 : xp1_q[N-1:0];
      relu_d  = x1_q[N-1] ? '0 : x1_q;
      relu6_d = x1_q[N-1] ? '0 : (x1_q > C6) ? C6 : x1_q;
      prod    = $signed({{(P-N){x2_q[N-1]}}, x2_q}) * $signed({{(P-N){1'b0}}, r2_q});
      hsw     = prod / C6W;
      y_d     = (m2_q == 3'd1) ? relu2_q :
                (m2_q == 3'd2) ? relu62_q :
                (m2_q == 3'd3) ? r2_q / SIX :
                (m2_q == 3'd4) ? sat(hsw) : x2_q;
   end

   assign adv         = !ov_q || out_ready;
   assign in_ready    = adv;
   assign busy        = v1_q || v2_q || ov_q;
   assign out_valid   = ov_q;
   assign out_data    = od_q;
   assign out_channel = oc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         ov_q     <= 1'b0;
         x1_q     <= '0;
         x2_q     <= '0;
         xp1_q    <= '0;
         r2_q     <= '0;
         relu2_q  <= '0;
         relu62_q <= '0;
         od_q     <= '0;
         ch1_q    <= '0;
         ch2_q    <= '0;
         oc_q     <= '0;
         m1_q     <= '0;
         m2_q     <= '0;
      end else if (adv) begin
         v1_q     <= in_valid;
         x1_q     <= in_data;
         ch1_q    <= in_channel;
         m1_q     <= in_mode;
         xp1_q    <= xp_d;
         v2_q     <= v1_q;
         x2_q     <= x1_q;
         ch2_q    <= ch1_q;
         m2_q     <= m1_q;
         r2_q     <= r_d;
         relu2_q  <= relu_d;
         relu62_q <= relu6_d;
         ov_q     <= v2_q;
         // Output registers keep their last sample across bubbles
         if (v2_q) begin
            od_q <= y_d;
            oc_q <= ch2_q;
         end
      end
   end
endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed and randomized checks of activation_pipe against an
// arithmetic reference model with a scoreboard on the output handshake.
module tb_activation_pipe;
   localparam int N = 16;
   localparam int CW = 4;

   logic clk = 0, rst = 0;
   logic in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
   logic [N-1:0] in_data = 0, out_data;
   logic [CW-1:0] in_channel = 0, out_channel;
   logic [2:0] in_mode = 0;

   typedef struct { logic [N-1:0] d; logic [CW-1:0] ch; int c; } exp_t;
   typedef struct { logic [N-1:0] d; logic [CW-1:0] ch; int l; int cy; } log_t;
   exp_t exp_q[$];
   log_t log_q[$];
   int n_chk = 0, n_err = 0, cyc = 0, n_acc = 0, n_out = 0;

   activation_pipe #(.N(N), .FRAC(8), .CHANNELS(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_channel(in_channel), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_channel(out_channel), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] model(input logic [N-1:0] xi, input logic [2:0] m);
      longint x, r, y;
      x = longint'($signed(xi));
      r = x + 768;
      r = (r < 0) ? 0 : (r > 1536) ? 1536 : r;
      case (m)
         3'd1: y = (x < 0) ? 0 : x;
         3'd2: y = (x < 0) ? 0 : (x > 1536) ? 1536 : x;
         3'd3: y = r / 6;
         3'd4: y = (x * r) / 1536;
         default: y = x;
      endcase
      y = (y > 32767) ? 32767 : (y < -32768) ? -32768 : y;
      return y[N-1:0];
   endfunction

   always @(negedge clk) if (rst) begin
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) check("unexpected_out", 1, 0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            check("data", out_data, e.d);
            check("chan", out_channel, e.ch);
            log_q.push_back('{out_data, out_channel, cyc - e.c, cyc});
         end
      end
      if (in_valid && in_ready) begin
         n_acc++;
         exp_q.push_back('{model(in_data, in_mode), in_channel, cyc});
      end
   end

   task automatic push(input logic [N-1:0] x, input logic [CW-1:0] ch, input logic [2:0] m);
      logic ok = 0;
      in_valid = 1; in_data = x; in_channel = ch; in_mode = m;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk) ok = in_ready;
         @(posedge clk) #1;
      end
      check("push_acc", ok, 1);
   endtask

   task automatic drain();
      in_valid = 0;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      #1 check("drain", exp_q.size(), 0);
   endtask

   logic [N-1:0] hs_x[4] = '{16'h0100, 16'hFF00, 16'h0400, 16'hFC00};
   logic [N-1:0] hs_y[4] = '{16'h00AA, 16'hFFAB, 16'h0400, 16'h0000};
   logic [2:0]   mx_m[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
   logic [N-1:0] mx_y[5] = '{16'h0780, 16'h0780, 16'h0600, 16'h0100, 16'h0780};
   logic [N-1:0] ex_x[3] = '{16'h7FFF, 16'h8000, 16'h8000};
   logic [2:0]   ex_m[3] = '{3'd4, 3'd1, 3'd0};
   logic [N-1:0] ex_y[3] = '{16'h7FFF, 16'h0000, 16'h8000};
   logic [N-1:0] bp_x[8];
   logic [2:0]   bp_m[8];

   initial begin
      logic [N+CW-1:0] held;
      logic acc;
      int sent;
      #23;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      @(negedge clk) #2 rst = 1;
      @(posedge clk) #1;

      log_q.delete();
      foreach (hs_x[k]) push(hs_x[k], CW'(k), 3'd4);
      drain();
      check("hs_count", log_q.size(), 4);
      foreach (hs_y[k]) if (k < log_q.size()) begin
         check("hs_val", log_q[k].d, hs_y[k]);
         check("hs_lat", log_q[k].l, 3);
      end

      log_q.delete();
      foreach (mx_m[k]) push(16'h0780, CW'(k), mx_m[k]);
      drain();
      check("mx_count", log_q.size(), 5);
      foreach (mx_y[k]) if (k < log_q.size()) begin
         check("mx_val", log_q[k].d, mx_y[k]);
         check("mx_tag", log_q[k].ch, CW'(k));
         check("mx_consec", log_q[k].cy - log_q[0].cy, k);
      end

      log_q.delete();
      foreach (ex_x[k]) push(ex_x[k], CW'(k), ex_m[k]);
      drain();
      check("ex_count", log_q.size(), 3);
      foreach (ex_y[k]) if (k < log_q.size()) check("ex_val", log_q[k].d, ex_y[k]);

      log_q.delete();
      foreach (bp_x[k]) begin bp_x[k] = N'($urandom); bp_m[k] = 3'($urandom_range(0, 7)); end
      sent = 0;
      held = 0;
      for (int c = 0; c < 60 && (sent < 8 || exp_q.size() != 0); c++) begin
         in_valid = (sent < 8);
         in_data = bp_x[sent % 8]; in_channel = CW'(sent); in_mode = bp_m[sent % 8];
         out_ready = !(c >= 5 && c < 9);
         @(negedge clk) acc = in_valid && in_ready;
         if (c >= 5 && c < 9) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            if (c > 5) check("stall_hold", {out_data, out_channel}, held);
            held = {out_data, out_channel};
         end
         @(posedge clk) #1;
         if (acc) sent++;
      end
      in_valid = 0; out_ready = 1;
      check("bp_count", log_q.size(), 8);
      foreach (log_q[k]) check("bp_order", log_q[k].ch, CW'(k));

      for (int i = 0; i < 60000 && n_acc < 10200; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = ($urandom_range(0, 2) == 0) ? N'($urandom) : N'($urandom_range(0, 4095) - 2048);
         in_channel = CW'($urandom);
         in_mode = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk) #1;
      end
      out_ready = 1;
      drain();
      check("balance", n_out, n_acc);

      out_ready = 0;
      for (int k = 0; k < 3; k++) push(N'($urandom), CW'(k + 1), 3'd0);
      in_valid = 0;
      check("pre_rst_busy", busy, 1);
      #3 rst = 0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_out_data", out_data, 0);
      check("arst_out_chan", out_channel, 0);
      exp_q.delete();
      @(negedge clk) #2 rst = 1;
      out_ready = 1;
      @(posedge clk) #1;
      log_q.delete();
      push(16'h0100, 4'd9, 3'd3);
      drain();
      check("post_rst_count", log_q.size(), 1);
      if (log_q.size() > 0) begin
         check("post_rst_lat", log_q[0].l, 3);
         check("post_rst_val", log_q[0].d, 16'h00AA);
         check("post_rst_chan", log_q[0].ch, 4'd9);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter N, default 16, meaning data width (signed two's complement, N >= 8).
REQ-002 SHALL have parameter FRAC, default 8, meaning fractional bits of the fixed-point format (FRAC <= N-4).
REQ-003 SHALL have parameter CHANNELS, default 16, meaning channel-tag range; tag width CW = $clog2(CHANNELS).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input sample present.
REQ-007 SHALL have port in_ready  output  1  pipeline accepts a sample this cycle.
REQ-008 SHALL have port in_data  input  N  signed input x.
REQ-009 SHALL have port in_channel  input  CW  channel tag, carried unchanged.
REQ-010 SHALL have port in_mode  input  3  per-sample activation select.
REQ-011 SHALL have port out_valid  output  1  output sample present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the output.
REQ-013 SHALL have port out_data  output  N  signed activation result.
REQ-014 SHALL have port out_channel  output  CW  tag of the output sample.
REQ-015 SHALL have port busy  output  1  high while any pipeline stage holds a valid sample.

Function
REQ-016 Mode encoding SHALL be 0 bypass (y=x), 1 ReLU, 2 ReLU6, 3 HSigmoid, 4 HSwish; codes 5-7 SHALL behave as bypass.
REQ-017 The block SHALL be a 3-stage pipeline: S1 registers x, tag, mode, and x+3.0 (N+1 bits, no wrap); S2 registers R = clamp(x+3.0, 0, 6.0) plus x, tag, mode, and the ReLU/ReLU6 results; S3 computes the selected result and drives the out_* registers.
REQ-018 Constants SHALL be 3.0 = 3<<FRAC and 6.0 = 6<<FRAC.
REQ-019 The mode results SHALL be:
- ReLU: max(x,0).
- ReLU6: clamp(x, 0, 6<<FRAC).
- HSigmoid: R/6, integer division.
- HSwish: (x*R)/(6<<FRAC), with a 2N+4-bit signed product.
All divisions SHALL truncate toward zero.
REQ-020 Every result SHALL be saturated to [-2^(N-1), 2^(N-1)-1] before output; no other rounding SHALL be applied.
REQ-021 A global advance enable SHALL be computed as adv = !out_valid || out_ready.
- in_ready SHALL equal adv.
- A sample SHALL be accepted only when in_valid && in_ready.
REQ-022 When adv=1, every stage SHALL shift forward one position and each stage valid bit SHALL follow its predecessor; an empty predecessor SHALL insert a bubble.
REQ-023 When adv=0, all stage registers and all outputs SHALL hold their values unchanged.
REQ-024 Latency SHALL be exactly 3 cycles from acceptance to out_valid when no stall occurs; each stall cycle SHALL add exactly one cycle.
REQ-025 With in_valid held high and out_ready held high, throughput SHALL be one sample per cycle.
REQ-026 Samples SHALL exit in acceptance order, with tag and mode kept aligned to their data.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_channel SHALL be stable.
REQ-028 When out_valid=0, out_data and out_channel SHALL hold their last values; they are don't-care for checking.
REQ-029 busy SHALL be the OR of the three stage valid bits.
REQ-030 When a handshake completes and a new sample advances in the same cycle, the new result SHALL be presented the next cycle with no bubble.

Reset
REQ-031 Asserting rst=0 at any time, including mid-stream or mid-stall, SHALL immediately clear all stage valid bits, out_valid, out_data, out_channel and busy to 0.
- In-flight samples SHALL be discarded.
- in_ready SHALL read 1 while rst=0.
REQ-032 After rst is deasserted, the first accepted sample SHALL appear exactly 3 cycles later, with no residual output.

Verification
REQ-033 HSwish, N=16, FRAC=8 -> required outputs:
- x=0x0100 -> 0x00AA.
- x=0xFF00 -> 0xFFAB.
- x=0x0400 -> 0x0400.
- x=0xFC00 -> 0x0000.
- Each result SHALL arrive 3 cycles after acceptance.
REQ-034 Mixed modes back-to-back on x=0x0780:
- bypass -> 0x0780.
- ReLU -> 0x0780.
- ReLU6 -> 0x0600.
- HSigmoid -> 0x0100.
- Code 6 -> 0x0780.
- Results SHALL arrive on consecutive cycles with tags 0..4 in order.
REQ-035 Backpressure: stream 8 samples and drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, out_data stable, no loss or duplication, order preserved.
REQ-036 Extremes: x=0x7FFF HSwish -> 0x7FFF; x=0x8000 in ReLU -> 0x0000; x=0x8000 in bypass -> 0x8000.
REQ-037 Reset with 3 samples in flight and out_ready=0 -> out_valid and busy drop to 0 asynchronously; after release, the next sample emerges after exactly 3 cycles.
REQ-038 Random stimulus with random in_valid/out_ready, checked against a bit-accurate reference model -> zero mismatches over 10k samples.
